// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: shifts a word MSB-first into an external sequence
// detector and records which bits completed a match. Optional abort input: SEQ_SCAN_ABORT_EN.
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             det_y,
`ifdef SEQ_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             det_x,
    output logic             det_rst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] match_mask,
    output logic [CW-1:0]    match_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MSB_ONEHOT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] shreg;
    // drv marks the bit on det_x now; sel marks the bit whose result det_y shows now
    logic [WIDTH-1:0] drv;
    logic [WIDTH-1:0] sel;
    logic             abort_hit;

`ifdef SEQ_SCAN_ABORT_EN
    assign abort_hit = abort && (state == S_CLEAR || state == S_SHIFT || state == S_DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            drv         <= '0;
            sel         <= '0;
            det_x       <= 1'b0;
            det_rst     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_mask  <= '0;
            match_count <= '0;
        end else if (abort_hit) begin
            state       <= S_IDLE;
            shreg       <= '0;
            drv         <= '0;
            sel         <= '0;
            det_x       <= 1'b0;
            det_rst     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_mask  <= '0;
            match_count <= '0;
        end else begin
            // The detector answers one cycle after each bit, so results trail drv by one.
            sel <= drv;
            if (det_y && (sel != '0)) begin
                match_mask  <= match_mask | sel;
                match_count <= match_count + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CLEAR;
                        shreg       <= data_in;
                        match_mask  <= '0;
                        match_count <= '0;
                        busy        <= 1'b1;
                        det_rst     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state   <= S_SHIFT;
                    det_rst <= 1'b0;
                    det_x   <= shreg[WIDTH-1];
                    shreg   <= shreg << 1;
                    drv     <= MSB_ONEHOT;
                end
                S_SHIFT: begin
                    drv <= drv >> 1;
                    if (drv[0]) begin
                        state <= S_DRAIN;
                        det_x <= 1'b0;
                    end else begin
                        det_x <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    det_x <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of bits per scan word (2..16).
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1), the width of match_count.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  the reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  the scan request, sampled only in IDLE.
REQ-006 SHALL have port data_in  input  WIDTH  the scan word, captured when start is accepted.
REQ-007 SHALL have port det_y  input  1  the Moore output of the external sequence detector.
REQ-008 SHALL have port det_x  output  1  the serial bit driven to the detector.
REQ-009 SHALL have port det_rst  output  1  the synchronous clear to the detector.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  a one-cycle completion pulse.
REQ-012 SHALL have port match_mask  output  WIDTH  where bit i=1 means a detector match completed on data_in[i].
REQ-013 SHALL have port match_count  output  CW  the number of ones in match_mask.

Function
REQ-014 SHALL implement the states IDLE, CLEAR, SHIFT, DRAIN and DONE.
REQ-015 SHALL accept start only in IDLE, which latches data_in into the shift register, clears match_mask/match_count, and moves to CLEAR; start in any other state is ignored.
REQ-016 SHALL, in CLEAR (1 cycle), drive det_rst=1 and det_x=0, then enter SHIFT; det_rst=0 in all other states.
REQ-017 SHALL, in SHIFT (exactly WIDTH cycles), drive det_x from the shift register MSB and shift left by one each cycle, so data_in is sent MSB first (bit WIDTH-1 first, bit 0 last).
REQ-018 SHALL sample det_y one cycle after each bit is driven: bit i's result is sampled in the following SHIFT cycle, or in DRAIN for bit 0.
REQ-019 SHALL, when a sampled det_y=1, set match_mask[i] and increment match_count in the same edge; match_count cannot overflow because CW holds WIDTH.
REQ-020 SHALL hold det_x=0 in DRAIN (1 cycle), then enter DONE.
REQ-021 SHALL drive done=1 for exactly one cycle in DONE, then return to IDLE; done is high in the (WIDTH+3)th cycle after the accepting edge.
REQ-022 SHALL hold match_mask/match_count stable from DONE until the next accepted start.
REQ-023 SHALL accept start asserted in the DONE cycle only on the next IDLE cycle, giving a minimum scan period of WIDTH+4 cycles.
REQ-024 SHALL drive det_x=0 in IDLE, CLEAR, DRAIN and DONE.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-scan, immediately force state IDLE, clear the shift register and bit counter, and drive busy=0, done=0, det_x=0, det_rst=0, match_mask=0 and match_count=0.
REQ-026 SHALL ignore start while reset is high and process the first start on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL, when macro SEQ_SCAN_ABORT_EN is defined, add input abort (1 bit).
REQ-028 SHALL, with SEQ_SCAN_ABORT_EN defined, treat abort=1 in CLEAR, SHIFT or DRAIN as follows: go to IDLE on the next edge, assert no done, and clear match_mask/match_count; abort is ignored in IDLE and DONE.
REQ-029 SHALL, when SEQ_SCAN_ABORT_EN is undefined, have no abort port, and every accepted scan runs to DONE.

Verification
REQ-030 SHALL use a bench detector model that is a Moore "11" detector: y=1 in the cycle after the second of two consecutive ones, overlapping, and cleared by det_rst.
REQ-031 SHALL cover: data_in=8'b0111_0110, start -> det_x sequence 0,1,1,1,0,1,1,0; done 11 cycles after acceptance; match_mask=8'b0011_0010; match_count=3.
REQ-032 SHALL cover: data_in=8'hFF -> match_mask=8'h7F, match_count=7; data_in=8'h00 -> match_mask=0, match_count=0, done still pulses.
REQ-033 SHALL cover: back-to-back 8'h01 then 8'h80, with start held high -> second scan accepted 12 cycles after the first; det_rst pulse prevents a cross-word match; second result match_count=0.
REQ-034 SHALL cover: start pulsed during SHIFT -> ignored; busy stays 1; results of the first scan unaffected.
REQ-035 SHALL cover: reset asserted in the 4th SHIFT cycle -> all outputs 0 immediately; a new start of 8'hFF after release -> match_count=7.
REQ-036 SHALL cover, with SEQ_SCAN_ABORT_EN: abort in the 3rd SHIFT cycle -> IDLE next cycle, no done, match_count=0; the next scan completes normally.
